// File: rtl/gpu_pkg.sv
// Shared definitions for the compositor output stage.
//   - config register addresses
//   - default raster timing and colour depth
//   - control word carried down the layer-latency delay line
//   - rgb packing helper for the default colour depth
package gpu_pkg;

    localparam logic [1:0] CFG_EN_MASK = 2'd0;   // layer enable shadow mask
    localparam logic [1:0] CFG_BG      = 2'd1;   // background colour
    localparam logic [1:0] CFG_IRQ_ACK = 2'd2;   // bit0=1 clears vblank irq

    localparam int DEF_COLOR_BITS = 2;

    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    // Raster qualifiers that must stay aligned with the returned layer pixels.
    typedef struct packed {
        logic drawing;
        logic hsync;
        logic vsync;
    } vid_ctl_t;

    function automatic logic [3*DEF_COLOR_BITS-1:0] pack_rgb(
        input logic [DEF_COLOR_BITS-1:0] r,
        input logic [DEF_COLOR_BITS-1:0] g,
        input logic [DEF_COLOR_BITS-1:0] b
    );
        return {r, g, b};
    endfunction

endpackage

// File: rtl/video_timing_param_m.sv
// Raster counters and timing decode.
//   clk, rst      pixel clock, async active-low reset
//   hcount/vcount raster position
//   hsync/vsync   active-low syncs decoded from the current position
//   visible       inside the active area
//   writable      vertical blanking (vcount >= V_VIS)
//   vblank_start  high on the last clock of the last visible line, i.e. the
//                 clock whose edge moves vcount to V_VIS
module video_timing_param_m
    import gpu_pkg::*;
#(
    parameter int H_VIS  = DEF_H_VIS,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_VIS  = DEF_V_VIS,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP,
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP,
    localparam int HCW   = $clog2(H_TOT),
    localparam int VCW   = $clog2(V_TOT)
) (
    input  logic           clk,
    input  logic           rst,
    output logic [HCW-1:0] hcount,
    output logic [VCW-1:0] vcount,
    output logic           hsync,
    output logic           vsync,
    output logic           visible,
    output logic           writable,
    output logic           vblank_start
);

    logic h_last;
    assign h_last = (hcount == HCW'(H_TOT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (h_last) begin
            hcount <= '0;
            vcount <= (vcount == VCW'(V_TOT - 1)) ? '0 : vcount + VCW'(1);
        end else begin
            hcount <= hcount + HCW'(1);
        end
    end

    assign hsync = !((hcount >= HCW'(H_VIS + H_FP)) &&
                     (hcount <  HCW'(H_VIS + H_FP + H_SYNC)));
    assign vsync = !((vcount >= VCW'(V_VIS + V_FP)) &&
                     (vcount <  VCW'(V_VIS + V_FP + V_SYNC)));

    assign visible      = (hcount < HCW'(H_VIS)) && (vcount < VCW'(V_VIS));
    assign writable     = (vcount >= VCW'(V_VIS));
    assign vblank_start = h_last && (vcount == VCW'(V_VIS - 1));

endmodule

// File: rtl/gpu_compositor_m.sv
// GPU output stage: raster timing, playfield coordinates for the layer
// engines, priority compositing of the returned layer pixels, config regs,
// frame counter and sticky vblank interrupt.
//   clk, rst            pixel clock, async active-low reset
//   xp, yp              playfield coordinates to the layers
//   visible, writable   undelayed raster status
//   layer_rgb/valid     layer pixels, LAYER_LAT clocks after xp/yp
//   cfg_we/addr/wdata   config write port
//   r, g, b             registered composited pixel
//   hsync, vsync        active-low syncs aligned with r/g/b
//   frame_count         frames since reset
//   vblank_irq          sticky vblank interrupt
module gpu_compositor_m
    import gpu_pkg::*;
#(
    parameter int COLOR_BITS  = DEF_COLOR_BITS,
    parameter int NUM_LAYERS  = 2,
    parameter int LAYER_LAT   = 1,
    parameter int H_VIS       = DEF_H_VIS,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_VIS       = DEF_V_VIS,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int SCALE_SHIFT = 1,
    parameter int WIN_X0      = 32,
    parameter int WIN_W       = 256,
    parameter int WIN_H       = 240
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic [7:0]                         xp,
    output logic [7:0]                         yp,
    output logic                               visible,
    output logic                               writable,
    input  logic [NUM_LAYERS*3*COLOR_BITS-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]              layer_valid,
    input  logic                               cfg_we,
    input  logic [1:0]                         cfg_addr,
    input  logic [7:0]                         cfg_wdata,
    output logic [COLOR_BITS-1:0]              r,
    output logic [COLOR_BITS-1:0]              g,
    output logic [COLOR_BITS-1:0]              b,
    output logic                               hsync,
    output logic                               vsync,
    output logic [15:0]                        frame_count,
    output logic                               vblank_irq
);

    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HCW    = $clog2(H_TOT);
    localparam int VCW    = $clog2(V_TOT);
    localparam int PW     = 3 * COLOR_BITS;
    // Only eight mask bits exist; higher layers have no enable bit.
    localparam int MASK_W = (NUM_LAYERS < 8) ? NUM_LAYERS : 8;
    localparam vid_ctl_t CTL_IDLE = '{drawing: 1'b0, hsync: 1'b1, vsync: 1'b1};

    logic [HCW-1:0] hcount;
    logic [VCW-1:0] vcount;
    logic           hsync_raw, vsync_raw, vblank_start;

    video_timing_param_m #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .hcount       (hcount),
        .vcount       (vcount),
        .hsync        (hsync_raw),
        .vsync        (vsync_raw),
        .visible      (visible),
        .writable     (writable),
        .vblank_start (vblank_start)
    );

    // ---- playfield coordinates -------------------------------------------
    // xp9 is modular: left of the window it wraps to >= 256 and so falls
    // outside the window by the same unsigned compare as the right side.
    logic [HCW-1:0] hs_scaled;
    logic [8:0]     xp9, yp9;
    logic           drawing;

    assign hs_scaled = hcount >> SCALE_SHIFT;
    assign xp9       = 9'(hs_scaled) - 9'(WIN_X0);
    assign yp9       = 9'(vcount >> SCALE_SHIFT);
    assign drawing   = visible && ({1'b0, xp9} < 10'(WIN_W)) && ({1'b0, yp9} < 10'(WIN_H));
    assign xp        = xp9[7:0];
    assign yp        = yp9[7:0];

    // ---- delay line matching the layer pipeline ---------------------------
    vid_ctl_t                 ctl_now;
    vid_ctl_t [LAYER_LAT:1]   ctl_pipe;

    assign ctl_now = '{drawing: drawing, hsync: hsync_raw, vsync: vsync_raw};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 1; j <= LAYER_LAT; j++) ctl_pipe[j] <= CTL_IDLE;
        end else begin
            ctl_pipe[1] <= ctl_now;
            for (int j = LAYER_LAT; j > 1; j--) ctl_pipe[j] <= ctl_pipe[j-1];
        end
    end

    // ---- config registers ---------------------------------------------
    logic [MASK_W-1:0] shadow_en, active_en;
    logic [PW-1:0]     bg_q;
    logic              en_wr, bg_wr, ack_wr;

    assign en_wr  = cfg_we && (cfg_addr == CFG_EN_MASK);
    assign bg_wr  = cfg_we && (cfg_addr == CFG_BG);
    assign ack_wr = cfg_we && (cfg_addr == CFG_IRQ_ACK) && cfg_wdata[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_en <= '1;
            active_en <= '1;
            bg_q      <= '0;
        end else begin
            if (en_wr) shadow_en <= cfg_wdata[MASK_W-1:0];
            if (bg_wr) bg_q      <= PW'(cfg_wdata);
            // A mask write landing on the commit clock bypasses the shadow.
            if (vblank_start)
                active_en <= en_wr ? cfg_wdata[MASK_W-1:0] : shadow_en;
        end
    end

    // ---- frame counter / irq --------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_count <= '0;
            vblank_irq  <= 1'b0;
        end else begin
            if (vblank_start) frame_count <= frame_count + 16'd1;
            if (vblank_start)  vblank_irq <= 1'b1;   // set beats ack
            else if (ack_wr)   vblank_irq <= 1'b0;
        end
    end

    // ---- priority mux ---------------------------------------------------
    logic [NUM_LAYERS-1:0] lane_en;

    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_lane_en
        if (gi < MASK_W) begin : g_masked
            assign lane_en[gi] = active_en[gi];
        end else begin : g_always
            assign lane_en[gi] = 1'b1;
        end
    end

    logic [PW-1:0] pix_sel, pix_q;

    // Walk from lowest to highest priority so layer 0 wins last.
    always_comb begin
        pix_sel = bg_q;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_valid[i] && lane_en[i]) pix_sel = layer_rgb[i*PW +: PW];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_q <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            pix_q <= ctl_pipe[LAYER_LAT].drawing ? pix_sel : '0;
            hsync <= ctl_pipe[LAYER_LAT].hsync;
            vsync <= ctl_pipe[LAYER_LAT].vsync;
        end
    end

    assign {r, g, b} = pix_q;

endmodule

// File: tb/tb_gpu_compositor_m.sv
// Directed bench: u_a uses full default timing (LAYER_LAT 1) for line-level
// checks; u_b uses a 24-clock line with full vertical timing (LAYER_LAT 3)
// so whole frames fit in a short run.
module tb_gpu_compositor_m;
    import gpu_pkg::*;

    localparam logic [5:0] C_L0 = pack_rgb(2'd3, 2'd1, 2'd0);  // 6'h34
    localparam logic [5:0] C_L1 = pack_rgb(2'd0, 2'd2, 2'd3);  // 6'h0B
    localparam logic [5:0] C_BG = 6'h2A;                       // r=2 g=2 b=2

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---- DUT A: default timing ----
    logic        rst_a;
    logic [7:0]  xp_a, yp_a, cfg_wdata_a;
    logic        visible_a, writable_a, cfg_we_a, hsync_a, vsync_a, irq_a;
    logic [11:0] layer_rgb_a;
    logic [1:0]  layer_valid_a, cfg_addr_a, r_a, g_a, b_a;
    logic [15:0] fc_a;

    gpu_compositor_m u_a (
        .clk(clk), .rst(rst_a), .xp(xp_a), .yp(yp_a),
        .visible(visible_a), .writable(writable_a),
        .layer_rgb(layer_rgb_a), .layer_valid(layer_valid_a),
        .cfg_we(cfg_we_a), .cfg_addr(cfg_addr_a), .cfg_wdata(cfg_wdata_a),
        .r(r_a), .g(g_a), .b(b_a), .hsync(hsync_a), .vsync(vsync_a),
        .frame_count(fc_a), .vblank_irq(irq_a)
    );

    // ---- DUT B: short lines, full frame height ----
    logic        rst_b;
    logic [7:0]  xp_b, yp_b, cfg_wdata_b;
    logic        visible_b, writable_b, cfg_we_b, hsync_b, vsync_b, irq_b;
    logic [11:0] layer_rgb_b;
    logic [1:0]  layer_valid_b, cfg_addr_b, r_b, g_b, b_b;
    logic [15:0] fc_b;

    gpu_compositor_m #(
        .LAYER_LAT(3), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .SCALE_SHIFT(1), .WIN_X0(0), .WIN_W(256), .WIN_H(240)
    ) u_b (
        .clk(clk), .rst(rst_b), .xp(xp_b), .yp(yp_b),
        .visible(visible_b), .writable(writable_b),
        .layer_rgb(layer_rgb_b), .layer_valid(layer_valid_b),
        .cfg_we(cfg_we_b), .cfg_addr(cfg_addr_b), .cfg_wdata(cfg_wdata_b),
        .r(r_b), .g(g_b), .b(b_b), .hsync(hsync_b), .vsync(vsync_b),
        .frame_count(fc_b), .vblank_irq(irq_b)
    );

    initial begin
        logic [7:0]  exp8;
        logic [17:0] exp_r;
        logic [5:0]  col;
        int          h, v, ln, f;

        rst_a = 1'b0; rst_b = 1'b0;
        cfg_we_a = 1'b0; cfg_addr_a = '0; cfg_wdata_a = '0;
        cfg_we_b = 1'b0; cfg_addr_b = '0; cfg_wdata_b = '0;
        layer_rgb_a = {C_L1, C_L0}; layer_valid_a = 2'b00;
        layer_rgb_b = {C_L1, C_L0}; layer_valid_b = 2'b11;
        repeat (3) @(negedge clk);

        // reset state: xp = (0 - 32) mod 512 -> 0xE0
        chk("rst_pix_a",    {hsync_a, vsync_a, r_a, g_a, b_a}, 8'hC0);
        chk("rst_raster_a", {visible_a, writable_a, xp_a, yp_a}, {2'b10, 8'hE0, 8'h00});
        chk("rst_fc_irq_a", {irq_a, fc_a}, 17'h0);

        // ---- A: three lines; bg, layer1 only, both layers ----
        rst_a = 1'b1;
        for (int n = 0; n < 2403; n++) begin
            if (n < 2) exp8 = 8'hC0;
            else begin
                h  = (n - 2) % 800;
                ln = (n - 2) / 800;
                col = (ln == 0) ? C_BG : (ln == 1) ? C_L1 : C_L0;
                exp8 = {!(h >= 656 && h < 752), 1'b1,
                        (h >= 64 && h < 576) ? col : 6'h00};
            end
            chk("pix_a", {hsync_a, vsync_a, r_a, g_a, b_a}, exp8);
            cfg_we_a      = (n == 0);
            cfg_addr_a    = CFG_BG;
            cfg_wdata_a   = 8'h2A;
            layer_valid_a = (n / 800 == 0) ? 2'b00 : (n / 800 == 1) ? 2'b10 : 2'b11;
            @(negedge clk);
        end

        // ---- A: async reset in the middle of a drawn line ----
        repeat (200) @(negedge clk);
        chk("pre_rst_a", {r_a, g_a, b_a}, C_L0);
        #2 rst_a = 1'b0;
        #1;
        chk("mid_rst_pix_a",    {hsync_a, vsync_a, r_a, g_a, b_a}, 8'hC0);
        chk("mid_rst_raster_a", {visible_a, writable_a, xp_a, yp_a}, {2'b10, 8'hE0, 8'h00});
        chk("mid_rst_fc_a",     {irq_a, fc_a}, 17'h0);
        @(negedge clk);
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        chk("restart_a", {visible_a, writable_a, xp_a, yp_a}, {2'b10, 8'hE1, 8'h00});

        // ---- B: two frames plus a line, full raster model ----
        rst_b = 1'b1;
        for (int n = 0; n < 25229; n++) begin
            h = n % 24;
            v = (n / 24) % 525;
            chk("raster_b", {visible_b, writable_b, xp_b, yp_b},
                {(h < 16 && v < 480), (v >= 480), 8'(h >> 1), 8'((v >> 1) & 8'hFF)});
            if (n < 4) exp8 = 8'hC0;
            else begin
                h = (n - 4) % 24;
                v = ((n - 4) / 24) % 525;
                f = (n - 4) / 12600;
                col = (f == 1) ? C_L1 : C_L0;
                exp8 = {!(h >= 18 && h < 22), !(v >= 490 && v < 492),
                        (h < 16 && v < 480) ? col : 6'h00};
            end
            chk("pix_b", {hsync_b, vsync_b, r_b, g_b, b_b}, exp8);
            exp_r[15:0] = (n < 11520) ? 16'h0000 : (n <= 20000) ? 16'h0001 :
                          (n < 24120) ? 16'hFFFF : 16'h0000;
            chk("fc_b", fc_b, exp_r[15:0]);
            chk("irq_b", irq_b, (n == 11520 || n >= 24120) ? 1 : 0);

            cfg_we_b = 1'b0; cfg_addr_b = 2'd0; cfg_wdata_b = 8'h00;
            case (n)
                2400:  begin cfg_we_b = 1'b1; cfg_addr_b = CFG_EN_MASK; cfg_wdata_b = 8'h02; end
                3000:  begin cfg_we_b = 1'b1; cfg_addr_b = 2'd3;        cfg_wdata_b = 8'h00; end
                11519: begin cfg_we_b = 1'b1; cfg_addr_b = CFG_IRQ_ACK; cfg_wdata_b = 8'h01; end
                11520: begin cfg_we_b = 1'b1; cfg_addr_b = CFG_IRQ_ACK; cfg_wdata_b = 8'h01; end
                24119: begin cfg_we_b = 1'b1; cfg_addr_b = CFG_EN_MASK; cfg_wdata_b = 8'h01; end
                24200: begin cfg_we_b = 1'b1; cfg_addr_b = CFG_IRQ_ACK; cfg_wdata_b = 8'hFE; end
                default: ;
            endcase
            if (n == 20000) begin
                force u_b.frame_count = 16'hFFFF;
                #1 release u_b.frame_count;
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
